// File: rtl/io_resp_pkg.sv
// Shared types and constants for the IN/OUT handshake responder and its BCD converter.
package io_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IN_WAIT,
        OUT_CONV,
        ACK
    } state_t;

    localparam logic [3:0] DIGIT_ENTER = 4'hF;
    localparam int BCD_ITER   = 10;
    localparam int BIN_W      = 10;
    localparam int BCD_DIGITS = 3;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    // Elaboration-time BCD of a constant, used for the saturation value.
    function automatic logic [BCD_W-1:0] to_bcd(input int unsigned v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/io_handshake_responder_if.sv
// CPU-side request/acknowledge bus of the IN/OUT responder.
interface io_handshake_responder_if #(
    parameter int DW = 32
);
    logic          req_in;
    logic          req_out;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          ack;
    logic          busy;

    modport master (output req_in, req_out, wr_data, input rd_data, ack, busy);
    modport slave  (input req_in, req_out, wr_data, output rd_data, ack, busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to 3-digit BCD converter, one iteration per clock.
// o_done is high during the cycle whose closing edge commits the final iteration; o_bcd is valid then.
module bin2bcd_seq
    import io_resp_pkg::*;
(
    input  logic             clock,
    input  logic             n_reset,
    input  logic             i_start,
    input  logic [BIN_W-1:0] i_bin,
    output logic             o_done,
    output logic [BCD_W-1:0] o_bcd
);
    logic [BIN_W-1:0]       r_bin;
    logic [BCD_W-1:0]       r_bcd;
    logic [3:0]             r_cnt;
    logic                   r_run;
    logic [BCD_W-1:0]       w_adj;
    logic [BCD_W+BIN_W-1:0] w_shift;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
        w_shift = {w_adj, r_bin} << 1;
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_bin <= i_bin;
            r_bcd <= '0;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_bin <= w_shift[BIN_W-1:0];
            r_bcd <= w_shift[BCD_W+BIN_W-1:BIN_W];
            r_cnt <= r_cnt + 4'd1;
            if (o_done) begin
                r_run <= 1'b0;
            end
        end
    end

    assign o_done = r_run && (r_cnt == 4'(BCD_ITER - 1));
    assign o_bcd  = w_shift[BCD_W+BIN_W-1:BIN_W];
endmodule

// File: rtl/io_handshake_responder.sv
// Device-side responder for CPU IN/OUT: switch-digit decimal entry and serial BCD display output.
// Define IO_IN_TIMEOUT_EN to bound the IN digit wait to TIMEOUT_CYCLES clocks.
module io_handshake_responder
    import io_resp_pkg::*;
#(
    parameter int DW             = 32,
    parameter int MAX_VAL        = 999,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                    clock,
    input  logic                    n_reset,
    io_handshake_responder_if.slave bus,
    input  logic                    btn_pulse,
    input  logic [3:0]              sw_digit,
    output logic [3:0]              centena,
    output logic [3:0]              dezena,
    output logic [3:0]              unidade,
    output logic                    led_wait,
    output logic                    ovf,
    output logic                    timeout
);
    localparam int               ACC_W   = BIN_W + 4;
    localparam logic [DW-1:0]    MAX_DW  = DW'(MAX_VAL);
    localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);
    localparam logic [BCD_W-1:0] MAX_BCD = to_bcd(MAX_VAL);

    if (MAX_VAL < 0 || MAX_VAL > 2**BIN_W - 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("io_handshake_responder: MAX_VAL must fit in 10 bits, TIMEOUT_CYCLES must be positive");
    end

    state_t           r_state, w_state_nxt;
    logic             r_armed;
    logic [BIN_W-1:0] r_acc;
    logic [BCD_W-1:0] r_acc_bcd;
    logic [BCD_W-1:0] r_disp;
    logic [DW-1:0]    r_rd_data;
    logic             r_ovf;
    logic             w_accept, w_take_out, w_digit, w_enter, w_tmo_hit;
    logic             w_conv_done;
    logic [BCD_W-1:0] w_conv_bcd;
    logic [BIN_W-1:0] w_conv_bin;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_acc_sat;
    logic             w_ack, w_busy, w_led;

    assign w_accept   = (r_state == IDLE) && r_armed && (bus.req_in || bus.req_out);
    assign w_take_out = w_accept && bus.req_out;
    assign w_digit    = (r_state == IN_WAIT) && btn_pulse && (sw_digit <= 4'd9);
    assign w_enter    = (r_state == IN_WAIT) && btn_pulse && (sw_digit == DIGIT_ENTER);
    assign w_conv_bin = (bus.wr_data > MAX_DW) ? MAX_BIN : bus.wr_data[BIN_W-1:0];
    assign w_acc_next = ACC_W'(r_acc) * ACC_W'(10) + ACC_W'(sw_digit);
    assign w_acc_sat  = w_acc_next > ACC_W'(MAX_VAL);

    bin2bcd_seq u_bin2bcd (
        .clock   (clock),
        .n_reset (n_reset),
        .i_start (w_take_out),
        .i_bin   (w_conv_bin),
        .o_done  (w_conv_done),
        .o_bcd   (w_conv_bcd)
    );

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_busy      = 1'b1;
        w_led       = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (w_accept) begin
                    w_state_nxt = bus.req_out ? OUT_CONV : IN_WAIT;
                end
            end
            IN_WAIT: begin
                w_led = 1'b1;
                if (w_enter || w_tmo_hit) begin
                    w_state_nxt = ACK;
                end
            end
            OUT_CONV: begin
                if (w_conv_done) begin
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                w_ack       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The accumulator is kept in binary for rd_data and in BCD for the live echo.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_armed   <= 1'b0;
            r_acc     <= '0;
            r_acc_bcd <= '0;
            r_disp    <= '0;
            r_rd_data <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_armed <= 1'b0;
            end else if (!bus.req_in && !bus.req_out) begin
                r_armed <= 1'b1;
            end
            if (w_accept) begin
                r_acc     <= '0;
                r_acc_bcd <= '0;
            end
            if (w_take_out) begin
                r_ovf <= bus.wr_data > MAX_DW;
            end
            if (w_digit) begin
                r_acc     <= w_acc_sat ? MAX_BIN : w_acc_next[BIN_W-1:0];
                r_acc_bcd <= w_acc_sat ? MAX_BCD : {r_acc_bcd[BCD_W-5:0], sw_digit};
                r_disp    <= w_acc_sat ? MAX_BCD : {r_acc_bcd[BCD_W-5:0], sw_digit};
            end
            if (w_enter) begin
                r_rd_data <= DW'(r_acc);
            end else if (w_tmo_hit) begin
                r_rd_data <= '0;
            end
            if ((r_state == OUT_CONV) && w_conv_done) begin
                r_disp <= w_conv_bcd;
            end
        end
    end

`ifdef IO_IN_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_timeout;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            if ((r_state != IN_WAIT) || btn_pulse) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_accept) begin
                r_timeout <= 1'b0;
            end else if (w_tmo_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign w_tmo_hit = (r_state == IN_WAIT) && !btn_pulse && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign timeout   = r_timeout;
`else
    assign w_tmo_hit = 1'b0;
    assign timeout   = 1'b0;
`endif

    assign bus.ack     = w_ack;
    assign bus.busy    = w_busy;
    assign bus.rd_data = r_rd_data;
    assign led_wait    = w_led;
    assign ovf         = r_ovf;
    assign centena     = r_disp[11:8];
    assign dezena      = r_disp[7:4];
    assign unidade     = r_disp[3:0];
endmodule
